// File: rtl/dmem_sized.sv
// Sized data memory: byte/half/word stores with lane merge, sign/zero-extended loads, misalign flag.
// Completes LATENCY cycles after acceptance with a one-cycle ready pulse; new requests are taken only in IDLE or DONE.
module dmem_sized #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            accept, mis_in;
  logic            we_q, uns_q, mis_q;
  logic [1:0]      size_q, lane_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wd_q;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     word, wmerge, ldata;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic            unused_abits;

  // Address bits above the word index wrap modulo DEPTH.
  assign unused_abits = ^a[31:AW+2];

  assign accept = req && (state == IDLE || state == DONE);

  always_comb begin
    mis_in = 1'b0;
    case (size)
      2'b01:   mis_in = a[0];
      2'b10:   mis_in = (a[1:0] != 2'b00);
      2'b11:   mis_in = 1'b1;
      default: mis_in = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: ;
    endcase
    if (accept) begin
      cnt_n   = 4'(LATENCY);
      state_n = (LATENCY == 0) ? DONE : WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      mis_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
      idx_q  <= '0;
      wd_q   <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        we_q   <= we;
        uns_q  <= uns;
        mis_q  <= mis_in;
        size_q <= size;
        lane_q <= a[1:0];
        idx_q  <= a[AW+1:2];
        wd_q   <= wd;
      end
    end
  end

  assign word = mem[idx_q];
  assign bsel = word[{lane_q, 3'b000} +: 8];
  assign hsel = lane_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    wmerge = word;
    case (size_q)
      2'b00: wmerge[{lane_q, 3'b000} +: 8] = wd_q[7:0];
      2'b01: begin
        if (lane_q[1]) wmerge[31:16] = wd_q[15:0];
        else           wmerge[15:0]  = wd_q[15:0];
      end
      default: wmerge = wd_q;
    endcase
  end

  // Commit on the edge closing DONE; reset forces IDLE first, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (state == DONE && we_q && !mis_q) mem[idx_q] <= wmerge;
  end

  always_comb begin
    ldata = word;
    case (size_q)
      2'b00:   ldata = {{24{~uns_q & bsel[7]}}, bsel};
      2'b01:   ldata = {{16{~uns_q & hsel[15]}}, hsel};
      default: ldata = word;
    endcase
  end

  assign ready    = (state == DONE);
  assign misalign = ready && mis_q;
  assign rd       = (ready && !we_q && !mis_q) ? ldata : 32'd0;

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: three latency variants against a byte-array reference model.
module tb_dmem_sized;

  localparam int DEPTH = 64;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, uns;
  logic [1:0]  size;
  logic [31:0] a, wd;
  logic        req_w [3];
  logic [31:0] rd_w  [3];
  logic        rdy_w [3];
  logic        mis_w [3];

  int lat_of [3] = '{0, 1, 3};
  bit [7:0] mb [3][NB];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_sized #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req(req_w[0]), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .rd(rd_w[0]), .ready(rdy_w[0]), .misalign(mis_w[0]));
  dmem_sized #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req_w[1]), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .rd(rd_w[1]), .ready(rdy_w[1]), .misalign(mis_w[1]));
  dmem_sized #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req(req_w[2]), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .rd(rd_w[2]), .ready(rdy_w[2]), .misalign(mis_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit mdl_mis(input bit [1:0] sz, input bit [31:0] ad);
    return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0);
  endfunction

  function automatic bit [31:0] mdl_load(input int k, input bit [1:0] sz, input bit u, input bit [31:0] ad);
    int n = 1 << sz;
    int base = int'(ad % NB);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mb[k][(base + i) % NB]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic mdl_store(input int k, input bit [1:0] sz, input bit [31:0] ad, input bit [31:0] d);
    int n = 1 << sz;
    int base = int'(ad % NB);
    for (int i = 0; i < n; i++) mb[k][(base + i) % NB] = d[8*i +: 8];
  endtask

  // Issue one access on instance k; returns at the negedge inside its ready cycle.
  task automatic access(input int k, input bit w, input bit [1:0] sz, input bit u,
                        input bit [31:0] ad, input bit [31:0] d, input string tag);
    int cyc;
    bit m;
    logic [31:0] e;
    we = w; size = sz; uns = u; a = ad; wd = d; req_w[k] = 1'b1;
    @(posedge clk);
    #1 req_w[k] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rdy_w[k] !== 1'b1 && cyc < 40);
    chk({tag, "_lat"}, 32'(cyc), 32'(lat_of[k] + 1));
    if (rdy_w[k] !== 1'b1) return;
    m = mdl_mis(sz, ad);
    e = (m || w) ? 32'd0 : mdl_load(k, sz, u, ad);
    chk({tag, "_rd"}, rd_w[k], e);
    chk({tag, "_mis"}, 32'(mis_w[k]), 32'(m));
    if (w && !m) mdl_store(k, sz, ad, d);
  endtask

  // Hold req on a load and check ready spacing across n pulses.
  task automatic held(input int k, input int n, input string tag);
    int last = -1;
    int t = 0;
    int got = 0;
    we = 1'b0; size = 2'd2; uns = 1'b0; a = 32'h8; wd = 32'd0;
    req_w[k] = 1'b1;
    while (got < n && t < 100) begin
      @(negedge clk);
      t++;
      if (rdy_w[k] === 1'b1) begin
        chk({tag, "_rd"}, rd_w[k], mdl_load(k, 2'd2, 1'b0, 32'h8));
        if (last >= 0) chk({tag, "_spacing"}, 32'(t - last), 32'(lat_of[k] + 1));
        last = t;
        got++;
      end
    end
    req_w[k] = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
    repeat (lat_of[k] + 2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    bit [31:0] old40;
    reset = 1'b1;
    we = 1'b0; uns = 1'b0; size = 2'd0; a = 32'd0; wd = 32'd0;
    for (int k = 0; k < 3; k++) req_w[k] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy_w[k]), 32'd0);
      chk("rst_mis", 32'(mis_w[k]), 32'd0);
      chk("rst_rd", rd_w[k], 32'd0);
    end
    reset = 1'b0;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++) access(k, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "init");

    // Directed cases on LATENCY=1
    access(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "w_st");
    access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "w_ld");
    chk("w_ld_val", rd_w[1], 32'hDEADBEEF);
    @(negedge clk);
    chk("pulse_once", 32'(rdy_w[1]), 32'd0);

    access(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "bm_init");
    access(1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, "bm_st");
    access(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "bm_ldw");
    chk("bm_word", rd_w[1], 32'h1122AA44);
    access(1, 1'b0, 2'd0, 1'b0, 32'h21, 32'd0, "bm_lds");
    chk("bm_sbyte", rd_w[1], 32'hFFFFFFAA);
    access(1, 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, "bm_ldu");
    chk("bm_ubyte", rd_w[1], 32'h000000AA);

    access(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "h_init");
    access(1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, "h_st");
    access(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "h_ldw");
    chk("h_word", rd_w[1], 32'h80013344);
    access(1, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, "h_lds");
    chk("h_shalf", rd_w[1], 32'hFFFF8001);

    access(1, 1'b1, 2'd2, 1'b0, 32'h31, 32'hCAFEF00D, "mis_w");
    chk("mis_w_flag", 32'(mis_w[1]), 32'd1);
    access(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, "mis_w_after");
    access(1, 1'b1, 2'd3, 1'b0, 32'h30, 32'h12345678, "mis_11");
    chk("mis_11_flag", 32'(mis_w[1]), 32'd1);
    access(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, "mis_11_after");

    // Back-to-back with held req, plus aliasing
    held(0, 6, "held_l0");
    held(2, 5, "held_l3");
    access(0, 1'b1, 2'd2, 1'b0, 32'(DEPTH * 4 + 8), 32'h5A5A1234, "alias_st0");
    access(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, "alias_ld0");
    chk("alias_val0", rd_w[0], 32'h5A5A1234);
    access(2, 1'b1, 2'd2, 1'b0, 32'(DEPTH * 4 + 8), 32'hA5A54321, "alias_st3");
    access(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, "alias_ld3");
    chk("alias_val3", rd_w[2], 32'hA5A54321);
    @(negedge clk);

    // req pulse during WAIT must not start a second access
    we = 1'b0; size = 2'd2; uns = 1'b0; a = 32'h8;
    req_w[2] = 1'b1;
    @(posedge clk);
    #1 req_w[2] = 1'b0;
    @(negedge clk);
    req_w[2] = 1'b1;
    @(posedge clk);
    #1 req_w[2] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy_w[2] === 1'b1) cnt++;
    end
    chk("wait_ignore", 32'(cnt), 32'd1);

    // Reset during WAIT of a store
    old40 = mdl_load(1, 2'd2, 1'b0, 32'h40);
    we = 1'b1; size = 2'd2; a = 32'h40; wd = ~old40;
    req_w[1] = 1'b1;
    @(posedge clk);
    #1 req_w[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_ready", 32'(rdy_w[1]), 32'd0);
    chk("rstw_rd", rd_w[1], 32'd0);
    chk("rstw_mis", 32'(mis_w[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, "rstw_ld");
    chk("rstw_old", rd_w[1], old40);
    @(negedge clk);

    // Reset during DONE of a store: ready drops at once, write is dropped
    we = 1'b1; size = 2'd2; a = 32'h40; wd = old40 ^ 32'h0F0F0F0F;
    req_w[1] = 1'b1;
    @(posedge clk);
    #1 req_w[1] = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (rdy_w[1] !== 1'b1 && cnt < 10);
    chk("rstd_pre", 32'(rdy_w[1]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstd_ready", 32'(rdy_w[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, "rstd_ld");
    chk("rstd_old", rd_w[1], old40);

    // Randomized traffic across all three latencies
    repeat (300) begin
      int k;
      bit w, u;
      bit [1:0] sz;
      k  = int'($urandom_range(0, 2));
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      access(k, w, sz, u, 32'($urandom_range(0, 1023)), $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
